level_len_meter: RTL and testbench

Downstream consumer of the start/stop level generator: samples a single-bit `level` signal, emits one-cycle rise and fall pulses, and measures the number of clock cycles the level stays high. Each completed high interval is reported as a length word through a one-entry valid/ready output slot. It sits directly after the pulse-to-level stage, turning its window into edge events and a duration measurement for downstream control logic.

---
 rtl/level_len_pkg.sv | 31 +++
 rtl/sat_counter.sv | 49 ++++
 rtl/level_len_meter.sv | 138 +++++++++++++
 tb/tb_level_len_meter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/level_len_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : level_len_pkg
//  Purpose : Shared types and constants for the level length meter.
//            - state_t       : two-state tracker of the monitored level
//            - DEFAULT_CNT_W : default width of the length counter
//            - sat_max()     : all-ones value of a counter of a given width
//  Revision: 1.0  initial release
// ============================================================================
package level_len_pkg;

  // The state doubles as the one-bit level history: IDLE means the last
  // sampled level was 0, HIGH means it was 1.
  typedef enum logic {
    IDLE = 1'b0,
    HIGH = 1'b1
  } state_t;

  localparam int DEFAULT_CNT_W = 16;

  // Largest value representable in 'w' bits, evaluated at elaboration time.
  // Width 32 is special-cased so the shift never exceeds the 32-bit result.
  function automatic logic [31:0] sat_max(input int unsigned w);
    if (w >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module  : sat_counter
//  Purpose : CNT_W-bit length counter with load-to-one, increment and
//            saturation at all-ones. A sticky flag records any increment
//            request that arrived while the counter was already saturated.
//  Ports   : clk   in   clock, rising edge
//            rst   in   synchronous active-high reset (cnt=0, ovf=0)
//            load  in   start a new interval: cnt<=1, ovf<=0 (beats inc)
//            inc   in   extend the interval by one cycle
//            cnt   out  current count
//            ovf   out  sticky overflow flag, cleared only by load/reset
//  Revision: 1.0  initial release
// ============================================================================
module sat_counter
  import level_len_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      cnt <= CNT_ONE;
      ovf <= 1'b0;
    end else if (inc) begin
      if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end else begin
        // Saturated: hold the count, remember that cycles were lost.
        ovf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/level_len_meter.sv
`default_nettype none
// ============================================================================
//  Module  : level_len_meter
//  Purpose : Samples a single-bit level, emits one-cycle rise/fall pulses
//            and measures the length of every high interval in clock cycles.
//            Each completed interval of at least MIN_LEN cycles (or one that
//            overflowed the counter) is offered through a one-entry
//            valid/ready slot. A finished measurement that finds the slot
//            occupied and not being drained is dropped and flagged.
//  Params  : CNT_W    counter / len_out width (2..32)
//            MIN_LEN  shortest reported interval (1..2^CNT_W-1)
//  Ports   : clk        in   clock, rising edge
//            rst        in   synchronous active-high reset
//            level      in   monitored level, synchronous to clk
//            rise_pulse out  one cycle after a sampled 0->1 change
//            fall_pulse out  one cycle after a sampled 1->0 change
//            len_valid  out  slot holds a length word
//            len_ready  in   consumer takes the word when len_valid is high
//            len_out    out  interval length, saturates at 2^CNT_W-1
//            len_ovf    out  interval exceeded the counter range
//            overrun    out  one-cycle pulse: measurement dropped, slot full
//  Revision: 1.0  initial release
// ============================================================================
module level_len_meter
  import level_len_pkg::*;
#(
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int MIN_LEN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             len_valid,
  input  logic             len_ready,
  output logic [CNT_W-1:0] len_out,
  output logic             len_ovf,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);

  state_t           state;
  logic             level_q;
  logic [CNT_W-1:0] cnt;
  logic             ovf_acc;

  logic             cnt_load;
  logic             cnt_inc;
  logic             meas_end;
  logic             meas_keep;
  logic             slot_open;
  logic             slot_accept;
  logic             word_load;

  // The FSM state is the registered level history.
  assign level_q = (state == HIGH);

  // A sampled rise restarts the counter; every further high sample extends it.
  assign cnt_load = !level_q && level;
  assign cnt_inc  =  level_q && level;

  // Measurement ends on the first low sample after a high run; the length
  // is the count accumulated so far (the low sample itself is not counted).
  assign meas_end    = level_q && !level;
  assign meas_keep   = (cnt >= MIN_LEN_C) || ovf_acc;
  // The slot can take a new word if it is empty or being drained this cycle,
  // so a consumer keeping len_ready high never sees a gap or an overrun.
  assign slot_accept = len_valid && len_ready;
  assign slot_open   = !len_valid || len_ready;
  assign word_load   = meas_end && meas_keep && slot_open;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .ovf  (ovf_acc)
  );

  // Edge-tracking FSM with registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (level) begin
            state      <= HIGH;
            rise_pulse <= 1'b1;
          end
        end
        HIGH: begin
          if (!level) begin
            state      <= IDLE;
            fall_pulse <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // One-entry output slot. len_out/len_ovf only change on a load, so they
  // stay stable for as long as the word is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_valid <= 1'b0;
      len_out   <= '0;
      len_ovf   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (word_load) begin
        len_valid <= 1'b1;
        len_out   <= cnt;
        len_ovf   <= ovf_acc;
      end else if (slot_accept) begin
        len_valid <= 1'b0;
      end
      if (meas_end && meas_keep && !slot_open) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_level_len_meter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_level_len_meter
//  Purpose : Self-checking bench. Two instances share stimulus:
//            dut_a (CNT_W=16, MIN_LEN=1) and dut_b (CNT_W=4, MIN_LEN=3).
//            A directed vector table, hand-written corner sequences and a
//            randomized run are compared against an interval-length model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_level_len_meter;

  logic        clk;
  logic        rst;
  logic        level;
  logic        len_ready;

  logic        a_rise, a_fall, a_valid, a_ovf, a_ovr;
  logic [15:0] a_out;
  logic        b_rise, b_fall, b_valid, b_ovf, b_ovr;
  logic [3:0]  b_out;

  int checks = 0;
  int errors = 0;

  level_len_meter #(.CNT_W(16), .MIN_LEN(1)) dut_a (
    .clk(clk), .rst(rst), .level(level),
    .rise_pulse(a_rise), .fall_pulse(a_fall),
    .len_valid(a_valid), .len_ready(len_ready),
    .len_out(a_out), .len_ovf(a_ovf), .overrun(a_ovr)
  );

  level_len_meter #(.CNT_W(4), .MIN_LEN(3)) dut_b (
    .clk(clk), .rst(rst), .level(level),
    .rise_pulse(b_rise), .fall_pulse(b_fall),
    .len_valid(b_valid), .len_ready(len_ready),
    .len_out(b_out), .len_ovf(b_ovf), .overrun(b_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Index 0 models dut_a, index 1 models dut_b. The model keeps the true,
  // unbounded run length and derives the reported value from it.
  int MAXV [2] = '{65535, 15};
  int MINL [2] = '{1, 3};
  bit m_prev [2];
  int m_run  [2];
  bit m_rise [2];
  bit m_fall [2];
  bit m_valid[2];
  int m_out  [2];
  bit m_ovf  [2];
  bit m_ovr  [2];

  task automatic model_edge(input int i, input logic r, input logic l, input logic rd);
    bit took;
    bit loaded;
    int len;
    bit of;
    if (r) begin
      m_prev[i] = 0; m_run[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
      m_valid[i] = 0; m_out[i] = 0; m_ovf[i] = 0; m_ovr[i] = 0;
      return;
    end
    took   = m_valid[i] && rd;
    loaded = 0;
    m_rise[i] = 0; m_fall[i] = 0; m_ovr[i] = 0;
    if (!m_prev[i] && l) begin
      m_rise[i] = 1;
      m_run[i]  = 1;
    end else if (m_prev[i] && l) begin
      m_run[i] = m_run[i] + 1;
    end else if (m_prev[i] && !l) begin
      m_fall[i] = 1;
      of  = (m_run[i] > MAXV[i]);
      len = of ? MAXV[i] : m_run[i];
      if (len >= MINL[i] || of) begin
        if (!m_valid[i] || rd) begin
          loaded     = 1;
          m_valid[i] = 1;
          m_out[i]   = len;
          m_ovf[i]   = of;
        end else begin
          m_ovr[i] = 1;
        end
      end
    end
    if (took && !loaded) m_valid[i] = 0;
    m_prev[i] = l;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model and compare both DUTs.
  task automatic step(input logic r, input logic l, input logic rd);
    rst = r; level = l; len_ready = rd;
    @(posedge clk);
    model_edge(0, r, l, rd);
    model_edge(1, r, l, rd);
    #1;
    check("model_a {rise,fall,valid,ovf,ovr,out}",
          {a_rise, a_fall, a_valid, a_ovf, a_ovr, 32'(a_out)},
          {m_rise[0], m_fall[0], m_valid[0], m_ovf[0], m_ovr[0], 32'(m_out[0])});
    check("model_b {rise,fall,valid,ovf,ovr,out}",
          {b_rise, b_fall, b_valid, b_ovf, b_ovr, 32'(b_out)},
          {m_rise[1], m_fall[1], m_valid[1], m_ovf[1], m_ovr[1], 32'(m_out[1])});
    if (b_rise && b_fall) check("b_rise_fall_exclusive", 1'b1, 1'b0);
  endtask

  task automatic run_level(input int n, input logic l, input logic rd);
    for (int k = 0; k < n; k++) step(1'b0, l, rd);
  endtask

  // ---------------- directed table for dut_a ----------------
  typedef struct {
    logic        r, l, rd;
    logic        rise, fall, valid;
    logic [15:0] out;
    logic        ovf, ovr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    rst = 1'b1; level = 1'b0; len_ready = 1'b0;

    // reset, level high 5 cycles, then low with len_ready held high
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd5, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 1'b0, 1'b0};

    for (int v = 0; v < 8; v++) begin
      step(tbl[v].r, tbl[v].l, tbl[v].rd);
      check($sformatf("table[%0d]", v),
            {a_rise, a_fall, a_valid, a_ovf, a_ovr, a_out},
            {tbl[v].rise, tbl[v].fall, tbl[v].valid, tbl[v].ovf, tbl[v].ovr, tbl[v].out});
    end

    // ---- saturation: 20-cycle interval on a 4-bit counter ----
    step(1'b1, 1'b0, 1'b1);
    run_level(20, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("b_sat_len", b_out, 4'd15);
    check("b_sat_ovf", b_ovf, 1'b1);
    check("b_sat_valid", b_valid, 1'b1);
    check("a_len20", a_out, 16'd20);
    check("a_len20_ovf", a_ovf, 1'b0);

    // ---- MIN_LEN filter: intervals of 2 then 3, consumer stalled ----
    step(1'b1, 1'b0, 1'b0);
    run_level(2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("b_short_fall", b_fall, 1'b1);
    check("b_short_dropped", b_valid, 1'b0);
    check("b_short_no_ovr", b_ovr, 1'b0);
    run_level(3, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("b_min_word", {b_valid, b_out, b_ovr}, {1'b1, 4'd3, 1'b0});
    check("a_min_overrun", a_ovr, 1'b1);

    // ---- overrun: 4 then 6 with len_ready low, then drain ----
    step(1'b1, 1'b0, 1'b0);
    run_level(4, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run_level(6, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("a_ovr_pulse", {a_ovr, a_valid, a_out}, {1'b1, 1'b1, 16'd4});
    step(1'b0, 1'b0, 1'b0);
    check("a_ovr_one_cycle", {a_ovr, a_valid, a_out}, {1'b0, 1'b1, 16'd4});
    step(1'b0, 1'b0, 1'b1);
    check("a_drain", a_valid, 1'b0);

    // ---- accept and load in the same cycle ----
    step(1'b1, 1'b0, 1'b0);
    run_level(2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run_level(7, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("a_swap", {a_valid, a_out, a_ovr}, {1'b1, 16'd7, 1'b0});

    // ---- reset mid-interval with level still high ----
    step(1'b1, 1'b0, 1'b1);
    run_level(3, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("a_rst_mid", {a_rise, a_fall, a_valid, a_ovf, a_ovr, a_out}, 22'd0);
    step(1'b0, 1'b1, 1'b1);
    check("a_rst_rerise", {a_rise, a_fall}, 2'b10);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("a_rst_restart_len", {a_fall, a_valid, a_out}, {1'b1, 1'b1, 16'd2});

    // ---- randomized intervals, ready and occasional reset ----
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 150; k++) begin
      int hi;
      int lo;
      hi = $urandom_range(1, 20);
      lo = $urandom_range(1, 3);
      for (int j = 0; j < hi; j++)
        step(($urandom_range(0, 199) == 0), 1'b1, ($urandom_range(0, 3) != 0));
      for (int j = 0; j < lo; j++)
        step(($urandom_range(0, 199) == 0), 1'b0, ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
